// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared widths and limits for the UART receive path
//
// Purpose: constants shared by the UART receive buffer and its sub-modules.
// Contents:
//   UART_DATA_W  - width of one received character
//   ERR_CNT_W    - width of the frame-error counter
//   ERR_CNT_MAX  - saturation value of the frame-error counter
package uart_pkg;

    localparam int              UART_DATA_W = 8;
    localparam int              ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

endpackage : uart_pkg

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - parameterised single-clock show-ahead FIFO
//
// Purpose: DEPTH-entry FIFO whose head entry is always visible on rdata.
// Ports:
//   clk    in   system clock
//   rstN   in   asynchronous active-low reset (pointers only)
//   push   in   write wdata this cycle; accepted when not full, or when full
//                and a pop happens in the same cycle
//   pop    in   discard the head entry; ignored when empty
//   wdata  in   WIDTH  data to write
//   rdata  out  WIDTH  head-of-FIFO data (valid when !empty)
//   full   out  FIFO holds DEPTH entries
//   empty  out  FIFO holds no entries
//   count  out  AW+1   number of stored entries, 0..DEPTH
module sync_fifo #(
    parameter int   WIDTH = 8,
    parameter int   DEPTH = 16,
    localparam int  AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Pointers carry one extra MSB so full and empty are distinguishable
    // when the low address bits match.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        pop_ok;
    logic        push_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    assign pop_ok  = pop && !empty;
    // When full, the slot being written is the head being popped; the head
    // is read combinationally this cycle, so the overwrite is safe.
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; stale contents are hidden by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

endmodule : sync_fifo

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive buffer between the Uart8 receiver and its consumer
//
// Purpose: captures one byte per rxDone high period, drops errored frames,
// buffers good bytes and hands them out over valid/ready, with a sticky
// overflow flag and a saturating frame-error counter.
// Ports:
//   clk       in   system clock (Uart8 clock domain)
//   rstN      in   asynchronous active-low reset
//   rxDone    in   Uart8 frame-complete level
//   rxErr     in   Uart8 frame error, sampled with rxDone
//   rxByte    in   8     received byte, valid while rxDone is high
//   outValid  out  a byte is available on outByte
//   outByte   out  8     head-of-buffer byte
//   outReady  in   consumer takes outByte when outValid && outReady
//   count     out  AW+1  number of buffered bytes
//   full      out  buffer holds DEPTH bytes
//   overflow  out  sticky: a good byte was dropped on a full buffer
//   errCount  out  8     saturating count of errored frames
//   clrFlags  in   synchronous clear of overflow and errCount
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int   DEPTH = 16,
    localparam int  AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   rxDone,
    input  logic                   rxErr,
    input  logic [UART_DATA_W-1:0] rxByte,
    output logic                   outValid,
    output logic [UART_DATA_W-1:0] outByte,
    input  logic                   outReady,
    output logic [AW:0]            count,
    output logic                   full,
    output logic                   overflow,
    output logic [ERR_CNT_W-1:0]   errCount,
    input  logic                   clrFlags
);

    logic                 rx_done_prev_q;
    logic                 overflow_q, overflow_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic cap;
    logic good_cap;
    logic err_cap;
    logic push;
    logic pop;
    logic ovf_evt;
    logic fifo_empty;

    // Reset to 1 so a byte already pending when reset releases is ignored.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rx_done_prev_q <= 1'b1;
        end else begin
            rx_done_prev_q <= rxDone;
        end
    end

    assign cap      = rxDone && !rx_done_prev_q;
    assign good_cap = cap && !rxErr;
    assign err_cap  = cap && rxErr;

    assign outValid = !fifo_empty;
    assign pop      = outValid && outReady;
    // A full buffer still accepts a byte when the head leaves in the same cycle.
    assign push     = good_cap && (!full || pop);
    assign ovf_evt  = good_cap && full && !pop;

    // New events take priority over a coincident clear.
    always_comb begin
        overflow_d  = overflow_q;
        err_count_d = err_count_q;
        if (ovf_evt) begin
            overflow_d = 1'b1;
        end else if (clrFlags) begin
            overflow_d = 1'b0;
        end
        if (err_cap) begin
            if (clrFlags) begin
                err_count_d = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end else if (err_count_q != ERR_CNT_MAX) begin
                err_count_d = err_count_q + 1'b1;
            end
        end else if (clrFlags) begin
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            overflow_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            overflow_q  <= overflow_d;
            err_count_q <= err_count_d;
        end
    end

    assign overflow = overflow_q;
    assign errCount = err_count_q;

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstN  (rstN),
        .push  (push),
        .pop   (pop),
        .wdata (rxByte),
        .rdata (outByte),
        .full  (full),
        .empty (fifo_empty),
        .count (count)
    );

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    logic       clk;
    logic       rstN;
    logic       rxDone;
    logic       rxErr;
    logic [7:0] rxByte;
    logic       outValid;
    logic [7:0] outByte;
    logic       outReady;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic [7:0] errCount;
    logic       clrFlags;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.DEPTH(16)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .rxDone   (rxDone),
        .rxErr    (rxErr),
        .rxByte   (rxByte),
        .outValid (outValid),
        .outByte  (outByte),
        .outReady (outReady),
        .count    (count),
        .full     (full),
        .overflow (overflow),
        .errCount (errCount),
        .clrFlags (clrFlags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with rxDone low.
    task automatic send_frame(input logic [7:0] b, input logic e, input int hold);
        rxByte = b;
        rxErr  = e;
        rxDone = 1'b1;
        repeat (hold) @(negedge clk);
        rxDone = 1'b0;
        rxErr  = 1'b0;
        @(negedge clk);
    endtask

    // Pops n bytes, comparing each against exp_q, then expects an empty buffer.
    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, outValid, 1);
            check({tag, "_byte"}, outByte, exp_q.pop_front());
            outReady = 1'b1;
            @(negedge clk);
        end
        outReady = 1'b0;
        check({tag, "_empty"}, outValid, 0);
    endtask

    task automatic pulse_clr();
        clrFlags = 1'b1;
        @(negedge clk);
        clrFlags = 1'b0;
    endtask

    initial begin
        rstN     = 1'b0;
        rxDone   = 1'b1;
        rxErr    = 1'b0;
        rxByte   = 8'h35;
        outReady = 1'b0;
        clrFlags = 1'b0;
        #1;
        check("rst_valid", outValid, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_err", errCount, 0);

        // Reset released while rxDone is high: stale byte ignored.
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (5) @(negedge clk);
        check("stale_valid", outValid, 0);
        check("stale_count", count, 0);
        rxDone = 1'b0;
        @(negedge clk);
        check("stale_count2", count, 0);

        // Three long frames, consumer stalled.
        send_frame(8'h35, 1'b0, 20);
        send_frame(8'hA0, 1'b0, 20);
        send_frame(8'hFF, 1'b0, 20);
        check("three_count", count, 3);
        repeat (4) @(negedge clk);
        check("stall_byte", outByte, 8'h35);
        check("stall_valid", outValid, 1);
        exp_q = '{8'h35, 8'hA0, 8'hFF};
        drain(3, "three");

        // Errored frame filtered, good one stored.
        send_frame(8'h12, 1'b1, 3);
        send_frame(8'h34, 1'b0, 3);
        check("err_cnt1", errCount, 1);
        check("err_count", count, 1);
        exp_q = '{8'h34};
        drain(1, "err");

        // 300 more error frames saturate the counter.
        for (int i = 0; i < 300; i++) send_frame(8'h12, 1'b1, 1);
        check("err_sat", errCount, 8'hFF);
        check("err_sat_count", count, 0);
        pulse_clr();
        check("clr_err0", errCount, 0);

        // errCount = 4, then overflow from 17 frames.
        for (int i = 0; i < 4; i++) send_frame(8'h99, 1'b1, 2);
        check("err_cnt4", errCount, 4);
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b0, 2);
        check("ovf_full", full, 1);
        check("ovf_flag", overflow, 1);
        check("ovf_count", count, 16);
        check("ovf_err4", errCount, 4);
        pulse_clr();
        check("clr_ovf", overflow, 0);
        check("clr_err", errCount, 0);
        check("clr_count", count, 16);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        drain(16, "ovf");

        // clrFlags coincident with an error capture: event wins.
        send_frame(8'h11, 1'b1, 2);
        send_frame(8'h11, 1'b1, 2);
        check("err_cnt2", errCount, 2);
        rxByte   = 8'h22;
        rxErr    = 1'b1;
        rxDone   = 1'b1;
        clrFlags = 1'b1;
        @(negedge clk);
        clrFlags = 1'b0;
        rxDone   = 1'b0;
        rxErr    = 1'b0;
        @(negedge clk);
        check("clr_vs_err", errCount, 1);

        // Full buffer, capture coincident with a pop.
        for (int i = 0; i < 16; i++) send_frame(8'h40 + 8'(i), 1'b0, 1);
        check("fp_full", full, 1);
        check("fp_ovf0", overflow, 0);
        rxByte   = 8'h5A;
        rxDone   = 1'b1;
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        check("fp_count", count, 16);
        check("fp_ovf", overflow, 0);
        check("fp_head", outByte, 8'h41);
        repeat (3) @(negedge clk);
        rxDone = 1'b0;
        @(negedge clk);
        for (int i = 1; i < 16; i++) exp_q.push_back(8'h40 + 8'(i));
        exp_q.push_back(8'h5A);
        drain(16, "fp");

        // Reset mid-drain with five bytes buffered.
        for (int i = 0; i < 7; i++) send_frame(8'h60 + 8'(i), 1'b0, 1);
        exp_q = '{8'h60, 8'h61};
        for (int i = 0; i < 2; i++) begin
            check("md_byte", outByte, exp_q.pop_front());
            outReady = 1'b1;
            @(negedge clk);
        end
        outReady = 1'b0;
        check("md_count5", count, 5);
        #2;
        rstN = 1'b0;
        #1;
        check("md_rst_valid", outValid, 0);
        check("md_rst_count", count, 0);
        check("md_rst_err", errCount, 0);
        @(negedge clk);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        check("md_post_valid", outValid, 0);
        check("md_post_count", count, 0);

        // Capture latency: visible one cycle after the capture cycle.
        rxByte = 8'h77;
        rxDone = 1'b1;
        check("lat_pre", outValid, 0);
        @(negedge clk);
        check("lat_valid", outValid, 1);
        check("lat_byte", outByte, 8'h77);
        repeat (2) @(negedge clk);
        rxDone = 1'b0;
        @(negedge clk);
        exp_q = '{8'h77};
        drain(1, "post");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_rx_fifo
